rx_channel: RTL and testbench
=============================

# rx_channel

Receive-side counterpart of the transmit channel. It takes real ADC samples at a strobed rate and downconverts them to complex baseband with an iterative (one stage per clock) CORDIC rotator. The I/Q pair is then decimated by a 3rd-order CIC filter. It sits between the ADC capture and the baseband/CSR logic in the uberclock SoC.

## Interface
- `IW`, 16: ADC sample width (signed).
- `OW`, 16: width of the mixed and decimated outputs.
- `NSTAGES`, 19: number of CORDIC iterations.
- `WW`, 19: CORDIC working width.
- `PW_I`, 19: width of the phase input.
- `PW`, 23: internal phase width.
- `DEC_LOG2`, 5: log2 of the CIC decimation ratio R (R = 32).

Ports (one clock; reset is asynchronous and active-high):
- `sys_clk` in 1: the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `phase_input` in PW_I: mixing phase. It is sampled together with `in_ce`.
- `rx_channel_input` in IW: signed ADC sample.
- `in_ce` in 1: sample strobe, one cycle wide.
- `rx_channel_mixed_x` / `rx_channel_mixed_y` out OW: signed baseband I/Q before decimation.
- `ce_mix` out 1: one-cycle pulse, mixed outputs are new.
- `rx_channel_output_x` / `rx_channel_output_y` out OW: signed decimated I/Q.
- `ce_down` out 1: one-cycle pulse, decimated outputs are new.
- `overrun` out 1: sticky flag, set when a sample is dropped.

## Operation
- **Reset:** every register is cleared to 0. The FSM goes to IDLE. All outputs, strobes, `overrun` and the decimation counter are 0.
- **Phase:**
  - P = `phase_input` << (PW−PW_I).
  - Rotation angle = 2^PW − P (mod 2^PW), so the sample is multiplied by e^{−j2πP/2^PW}. This mirrors the transmit side.
- **CORDIC FSM** has four states:
  - **IDLE:** `in_ce`=1 captures the sample and phase and moves to PRE.
  - **PRE:** one cycle.
    - x0 = sign-extend(input) << (WW−IW−1), y0 = 0.
    - Apply a pre-rotation by a multiple of 90°. The multiple is selected by the top 2 bits of (angle + 2^(PW−3)), which leaves a residual angle in [−π/4, π/4).
    - Then go to ROT.
  - **ROT:** NSTAGES cycles, i = 0..NSTAGES−1.
    - d = sign(z).
    - x ← x − d·(y>>>i); y ← y + d·(x>>>i); z ← z − d·atan_i.
    - On the last iteration, register the outputs as bits [WW−1:WW−OW] (truncation) and go to OUT.
  - **OUT:** one cycle with `ce_mix`=1, then back to IDLE.
- **Gain:** CORDIC gain ≈1.6468 is not compensated. The input headroom shift guarantees no overflow.
- **Overrun:** `in_ce` in any state other than IDLE drops the sample and sets `overrun`. The flag is cleared only by `rst`. An in-flight sample is never disturbed.
- **CIC** (I and Q identical, width CW = OW + 3·DEC_LOG2):
  - Three integrators update only on `ce_mix`. They use wrap-around two's-complement arithmetic; overflow is legal.
  - A mod-R counter advances on each `ce_mix`. At count R−1 it raises an internal decimate strobe for the next cycle.
  - In that cycle three combs (differential delay 1) process integrator-3. The result >>> 3·DEC_LOG2 is registered to `rx_channel_output_*`, and `ce_down` pulses in the following cycle.
  - DC gain is exactly 1.
- **Mid-operation reset:** `rst` during PRE/ROT/OUT abandons the sample. No `ce_mix` is produced, and CIC state is cleared.

## Timing
- `in_ce` in cycle t:
  - PRE in cycle t+1.
  - ROT in cycles t+2..t+NSTAGES+1.
  - `ce_mix` and valid mixed outputs in cycle t+NSTAGES+2 (t+21 by default).
- The next `in_ce` is accepted from t+NSTAGES+3. Minimum input spacing is 22 cycles.
- `ce_mix` to `ce_down` latency is 2 cycles, on every R-th `ce_mix`.
- Mixed outputs hold between `ce_mix` pulses. Decimated outputs hold between `ce_down` pulses.
- `ce_mix` and `ce_down` are never wider than 1 cycle.
- `in_ce` in the same cycle as OUT counts as an overrun.

## Structure
- Package `rx_channel_pkg` holds:
  - the atan table, atan_i = round(atan(2^−i)/(2π)·2^PW), for i < NSTAGES;
  - the FSM state enum;
  - the constant CW.
- Sub-module `cic3_decimator` holds the integrators, counter and combs for one rail. It is instantiated twice, for I and Q. The CORDIC FSM stays in the top level.

## Test plan
- **Reset values:** assert `rst` mid-stream. All outputs, `ce_mix`, `ce_down` and `overrun` read 0 one cycle later, and the FSM is IDLE.
- **DC at phase 0:** input 16384, `phase_input`=0, `in_ce` every 22 cycles.
  - `rx_channel_mixed_x` = 13490±2, `rx_channel_mixed_y` = 0±2.
  - `ce_mix` occurs exactly 21 cycles after each `in_ce`.
- **Quarter phase:** input 16384, `phase_input`=2^17. Result: `rx_channel_mixed_x` = 0±2, `rx_channel_mixed_y` = −13490±2.
- **Overrun:** `in_ce` at t and t+10. Exactly one `ce_mix` (at t+21), and `overrun`=1 from t+11 until reset.
- **CIC:** same DC stimulus as the phase-0 case, run for at least 4·R samples.
  - `ce_down` arrives every 32nd `ce_mix`, 2 cycles after it.
  - From the 3rd decimated output onward, `rx_channel_output_x` equals `rx_channel_mixed_x` exactly and `rx_channel_output_y` equals `rx_channel_mixed_y`.
- **Reset mid-rotation:** `rst` pulsed at t+5 after `in_ce`. No `ce_mix` is produced. An `in_ce` after release behaves as in the phase-0 case.

Source files
------------

// File: rtl/rx_channel_pkg.sv
// Shared definitions for the rx_channel receive path:
// FSM encoding, CIC register width and the CORDIC arctangent table.
package rx_channel_pkg;

  // CIC register width for the default OW = 16 and DEC_LOG2 = 5.
  localparam int unsigned CW = 16 + 3 * 5;

  typedef logic [1:0] cordic_state_t;

  localparam cordic_state_t StIdle = 2'd0;
  localparam cordic_state_t StPre  = 2'd1;
  localparam cordic_state_t StRot  = 2'd2;
  localparam cordic_state_t StOut  = 2'd3;

  localparam int unsigned AtanPw = 23;

  // atan(2^-i) expressed in units of 2^-AtanPw turns, rounded to nearest
  function automatic logic [AtanPw-1:0] atan_lut(input logic [4:0] idx);
    logic [AtanPw-1:0] a;
    case (idx)
      5'd0:    a = 23'd1048576;
      5'd1:    a = 23'd619011;
      5'd2:    a = 23'd327068;
      5'd3:    a = 23'd166025;
      5'd4:    a = 23'd83335;
      5'd5:    a = 23'd41708;
      5'd6:    a = 23'd20859;
      5'd7:    a = 23'd10430;
      5'd8:    a = 23'd5215;
      5'd9:    a = 23'd2608;
      5'd10:   a = 23'd1304;
      5'd11:   a = 23'd652;
      5'd12:   a = 23'd326;
      5'd13:   a = 23'd163;
      5'd14:   a = 23'd81;
      5'd15:   a = 23'd41;
      5'd16:   a = 23'd20;
      5'd17:   a = 23'd10;
      5'd18:   a = 23'd5;
      default: a = '0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/cic3_decimator.sv
// Third-order CIC decimator for one rail: three integrators clocked by ce_i,
// a mod-2^DEC_LOG2 counter and three unit-delay combs run once per output.
module cic3_decimator #(
  parameter int unsigned W        = 16,
  parameter int unsigned DEC_LOG2 = 5
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                ce_i,
  input  logic signed [W-1:0] data_i,
  output logic signed [W-1:0] data_o,
  output logic                ce_o
);

  localparam int unsigned Cw = W + 3 * DEC_LOG2;

  logic signed [Cw-1:0] int1_q, int1_d, int2_q, int2_d, int3_q, int3_d;
  logic signed [Cw-1:0] dly1_q, dly1_d, dly2_q, dly2_d, dly3_q, dly3_d;
  logic signed [Cw-1:0] data_ext, comb1, comb2, comb3;
  logic [DEC_LOG2-1:0]  cnt_q, cnt_d;
  logic                 dec_q, dec_d;
  logic                 ce_q, ce_d;
  logic signed [W-1:0]  out_q, out_d;

  always_comb begin
    data_ext = {{(Cw - W){data_i[W-1]}}, data_i};
    int1_d   = int1_q;
    int2_d   = int2_q;
    int3_d   = int3_q;
    cnt_d    = cnt_q;
    // Integrators wrap freely; the combs undo any overflow exactly.
    if (ce_i) begin
      int1_d = int1_q + data_ext;
      int2_d = int2_q + int1_q;
      int3_d = int3_q + int2_q;
      cnt_d  = cnt_q + DEC_LOG2'(1);
    end
    dec_d = ce_i && (cnt_q == '1);

    comb1  = int3_q - dly1_q;
    comb2  = comb1 - dly2_q;
    comb3  = comb2 - dly3_q;
    dly1_d = dly1_q;
    dly2_d = dly2_q;
    dly3_d = dly3_q;
    out_d  = out_q;
    if (dec_q) begin
      dly1_d = int3_q;
      dly2_d = comb1;
      dly3_d = comb2;
      out_d  = comb3[Cw-1 -: W];
    end
    ce_d = dec_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      int1_q <= '0;
      int2_q <= '0;
      int3_q <= '0;
      dly1_q <= '0;
      dly2_q <= '0;
      dly3_q <= '0;
      cnt_q  <= '0;
      dec_q  <= 1'b0;
      ce_q   <= 1'b0;
      out_q  <= '0;
    end else begin
      int1_q <= int1_d;
      int2_q <= int2_d;
      int3_q <= int3_d;
      dly1_q <= dly1_d;
      dly2_q <= dly2_d;
      dly3_q <= dly3_d;
      cnt_q  <= cnt_d;
      dec_q  <= dec_d;
      ce_q   <= ce_d;
      out_q  <= out_d;
    end
  end

  assign data_o = out_q;
  assign ce_o   = ce_q;

endmodule

// File: rtl/rx_channel.sv
// Receive channel: iterative CORDIC downconverts strobed real ADC samples to
// complex baseband, then a CIC3 decimator per rail reduces the rate by 2^DEC_LOG2.
module rx_channel
  import rx_channel_pkg::*;
#(
  parameter int unsigned IW       = 16,
  parameter int unsigned OW       = 16,
  parameter int unsigned NSTAGES  = 19,
  parameter int unsigned WW       = 19,
  parameter int unsigned PW_I     = 19,
  parameter int unsigned PW       = 23,
  parameter int unsigned DEC_LOG2 = 5
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic [PW_I-1:0]      phase_input,
  input  logic signed [IW-1:0] rx_channel_input,
  input  logic                 in_ce,
  output logic signed [OW-1:0] rx_channel_mixed_x,
  output logic signed [OW-1:0] rx_channel_mixed_y,
  output logic                 ce_mix,
  output logic signed [OW-1:0] rx_channel_output_x,
  output logic signed [OW-1:0] rx_channel_output_y,
  output logic                 ce_down,
  output logic                 overrun
);

  localparam int unsigned IterW      = $clog2(NSTAGES);
  localparam int unsigned Headroom   = WW - IW - 1;
  localparam logic [PW-1:0] EighthTurn = PW'(1) << (PW - 3);

  cordic_state_t        state_q, state_d;
  logic signed [IW-1:0] sample_q, sample_d;
  logic [PW-1:0]        angle_q, angle_d;
  logic signed [WW-1:0] x_q, x_d, y_q, y_d;
  logic signed [PW-1:0] z_q, z_d;
  logic [IterW-1:0]     iter_q, iter_d;
  logic signed [OW-1:0] mix_x_q, mix_x_d, mix_y_q, mix_y_d;
  logic                 ce_mix_q, ce_mix_d;
  logic                 overrun_q, overrun_d;

  logic [PW-1:0]        phase_scaled;
  logic [PW-1:0]        quad_sum;
  logic [1:0]           quadrant;
  logic signed [WW-1:0] sample_ext, x_init;
  logic signed [WW-1:0] x_shr, y_shr;
  logic [PW-1:0]        atan_step;
  logic                 ce_x, ce_y;

  always_comb begin
    phase_scaled = {phase_input, {(PW - PW_I){1'b0}}};
    // Rounding by an eighth turn picks the nearest quadrant, leaving |residual| <= 45 deg.
    quad_sum     = angle_q + EighthTurn;
    quadrant     = quad_sum[PW-1 -: 2];
    sample_ext   = {{(WW - IW){sample_q[IW-1]}}, sample_q};
    x_init       = sample_ext <<< Headroom;
    x_shr        = x_q >>> iter_q;
    y_shr        = y_q >>> iter_q;
    atan_step    = PW'(atan_lut(5'(iter_q)));
  end

  always_comb begin
    state_d   = state_q;
    sample_d  = sample_q;
    angle_d   = angle_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    iter_d    = iter_q;
    mix_x_d   = mix_x_q;
    mix_y_d   = mix_y_q;
    ce_mix_d  = 1'b0;
    overrun_d = overrun_q | (in_ce & (state_q != StIdle));

    case (state_q)
      StIdle: begin
        if (in_ce) begin
          sample_d = rx_channel_input;
          angle_d  = -phase_scaled;
          state_d  = StPre;
        end
      end
      StPre: begin
        z_d    = angle_q - {quadrant, {(PW - 2){1'b0}}};
        iter_d = '0;
        case (quadrant)
          2'd0: begin
            x_d = x_init;
            y_d = '0;
          end
          2'd1: begin
            x_d = '0;
            y_d = x_init;
          end
          2'd2: begin
            x_d = -x_init;
            y_d = '0;
          end
          default: begin
            x_d = '0;
            y_d = -x_init;
          end
        endcase
        state_d = StRot;
      end
      StRot: begin
        if (!z_q[PW-1]) begin
          x_d = x_q - y_shr;
          y_d = y_q + x_shr;
          z_d = z_q - atan_step;
        end else begin
          x_d = x_q + y_shr;
          y_d = y_q - x_shr;
          z_d = z_q + atan_step;
        end
        iter_d = iter_q + IterW'(1);
        if (iter_q == IterW'(NSTAGES - 1)) begin
          mix_x_d  = x_d[WW-1 -: OW];
          mix_y_d  = y_d[WW-1 -: OW];
          ce_mix_d = 1'b1;
          state_d  = StOut;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      sample_q  <= '0;
      angle_q   <= '0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      iter_q    <= '0;
      mix_x_q   <= '0;
      mix_y_q   <= '0;
      ce_mix_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sample_q  <= sample_d;
      angle_q   <= angle_d;
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      iter_q    <= iter_d;
      mix_x_q   <= mix_x_d;
      mix_y_q   <= mix_y_d;
      ce_mix_q  <= ce_mix_d;
      overrun_q <= overrun_d;
    end
  end

  cic3_decimator #(
    .W        (OW),
    .DEC_LOG2 (DEC_LOG2)
  ) u_cic_i (
    .clk_i  (sys_clk),
    .rst_i  (rst),
    .ce_i   (ce_mix_q),
    .data_i (mix_x_q),
    .data_o (rx_channel_output_x),
    .ce_o   (ce_x)
  );

  cic3_decimator #(
    .W        (OW),
    .DEC_LOG2 (DEC_LOG2)
  ) u_cic_q (
    .clk_i  (sys_clk),
    .rst_i  (rst),
    .ce_i   (ce_mix_q),
    .data_i (mix_y_q),
    .data_o (rx_channel_output_y),
    .ce_o   (ce_y)
  );

  assign rx_channel_mixed_x = mix_x_q;
  assign rx_channel_mixed_y = mix_y_q;
  assign ce_mix             = ce_mix_q;
  // Both rails share stimulus timing, so their strobes are identical.
  assign ce_down            = ce_x & ce_y;
  assign overrun            = overrun_q;

endmodule

// File: tb/tb_rx_channel.sv
// Directed self-checking bench for rx_channel: reset, CORDIC phase cases,
// overrun, CIC decimation timing/DC gain and reset during rotation.
module tb_rx_channel;
  import rx_channel_pkg::*;

  logic               sys_clk = 1'b0;
  logic               rst;
  logic [18:0]        phase_input;
  logic signed [15:0] rx_channel_input;
  logic               in_ce;
  logic signed [15:0] mixed_x, mixed_y, out_x, out_y;
  logic               ce_mix, ce_down, overrun;

  int total = 0;
  int bad   = 0;

  always #5 sys_clk = ~sys_clk;

  rx_channel dut (
    .sys_clk             (sys_clk),
    .rst                 (rst),
    .phase_input         (phase_input),
    .rx_channel_input    (rx_channel_input),
    .in_ce               (in_ce),
    .rx_channel_mixed_x  (mixed_x),
    .rx_channel_mixed_y  (mixed_y),
    .ce_mix              (ce_mix),
    .rx_channel_output_x (out_x),
    .rx_channel_output_y (out_y),
    .ce_down             (ce_down),
    .overrun             (overrun)
  );

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // One strobe, then wait (bounded) for ce_mix; returns latency and mixed outputs.
  task automatic send_sample(input logic signed [15:0] din, input logic [18:0] ph,
                             output int lat, output logic signed [15:0] mx,
                             output logic signed [15:0] my);
    rx_channel_input = din;
    phase_input      = ph;
    in_ce            = 1'b1;
    step();
    in_ce = 1'b0;
    lat   = 1;
    while (ce_mix !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    mx = mixed_x;
    my = mixed_y;
    step();
  endtask

  task automatic test_por();
    total++;
    if ({mixed_x, mixed_y, out_x, out_y, ce_mix, ce_down, overrun} !== '0) begin
      bad++;
      $display("FAIL por_outputs got=%h exp=0",
               {mixed_x, mixed_y, out_x, out_y, ce_mix, ce_down, overrun});
    end
    total++;
    if (dut.state_q !== StIdle) begin
      bad++;
      $display("FAIL por_state got=%0d exp=%0d", dut.state_q, StIdle);
    end
  endtask

  // DC at phase 0, strobe every 22 cycles for 132 samples; checks mixing and decimation.
  task automatic test_cic_dc();
    int   n_mix  = 0;
    int   n_down = 0;
    logic exp_mix, exp_down;
    rx_channel_input = 16'sd16384;
    phase_input      = '0;
    for (int cyc = 0; cyc < 132 * 22 + 4; cyc++) begin
      in_ce    = (cyc % 22 == 0) && (cyc < 132 * 22);
      exp_mix  = (cyc >= 21) && ((cyc - 21) % 22 == 0);
      exp_down = (cyc >= 23) && ((cyc - 23) % 22 == 0) && ((((cyc - 23) / 22) + 1) % 32 == 0);
      total++;
      if (ce_mix !== exp_mix) begin
        bad++;
        $display("FAIL dc_ce_mix cyc=%0d got=%b exp=%b", cyc, ce_mix, exp_mix);
      end
      total++;
      if (ce_down !== exp_down) begin
        bad++;
        $display("FAIL dc_ce_down cyc=%0d got=%b exp=%b", cyc, ce_down, exp_down);
      end
      if (exp_mix) begin
        n_mix++;
        total++;
        if (mixed_x < 13488 || mixed_x > 13492 || mixed_y < -2 || mixed_y > 2) begin
          bad++;
          $display("FAIL dc_mixed n=%0d got=(%0d,%0d) exp=(13490,0)+-2", n_mix, mixed_x,
                   mixed_y);
        end
      end
      if (exp_down) begin
        n_down++;
        if (n_down >= 3) begin
          total++;
          if (out_x !== mixed_x || out_y !== mixed_y || out_x < 13488 || out_x > 13492) begin
            bad++;
            $display("FAIL cic_dc_gain n=%0d got=(%0d,%0d) exp=(%0d,%0d)", n_down, out_x,
                     out_y, mixed_x, mixed_y);
          end
        end
      end
      step();
    end
    in_ce = 1'b0;
    total++;
    if (n_down != 4) begin
      bad++;
      $display("FAIL cic_down_count got=%0d exp=4", n_down);
    end
  endtask

  task automatic test_phase_table();
    int          vin[6] = '{16384, 16384, 16384, -16384, -16384, 16384};
    int          vph[6] = '{131072, 262144, 393216, 0, 131072, 0};
    int          ex[6]  = '{0, -13490, 0, -13490, 0, 13490};
    int          ey[6]  = '{-13490, 0, 13490, 0, 13490, 0};
    int          lat, dx, dy;
    logic signed [15:0] mx, my;
    for (int k = 0; k < 6; k++) begin
      send_sample(16'(vin[k]), 19'(vph[k]), lat, mx, my);
      total++;
      if (lat != 21) begin
        bad++;
        $display("FAIL phase_latency k=%0d got=%0d exp=21", k, lat);
      end
      dx = int'(mx) - ex[k];
      dy = int'(my) - ey[k];
      total++;
      if (dx < -2 || dx > 2 || dy < -2 || dy > 2) begin
        bad++;
        $display("FAIL phase_value k=%0d got=(%0d,%0d) exp=(%0d,%0d)+-2", k, mx, my, ex[k],
                 ey[k]);
      end
    end
  endtask

  task automatic test_overrun();
    rx_channel_input = 16'sd16384;
    phase_input      = '0;
    for (int cyc = 0; cyc < 46; cyc++) begin
      in_ce = (cyc == 0) || (cyc == 10);
      total++;
      if (ce_mix !== (cyc == 21)) begin
        bad++;
        $display("FAIL ovr_ce_mix cyc=%0d got=%b exp=%b", cyc, ce_mix, (cyc == 21));
      end
      total++;
      if (overrun !== (cyc >= 11)) begin
        bad++;
        $display("FAIL ovr_flag cyc=%0d got=%b exp=%b", cyc, overrun, (cyc >= 11));
      end
      step();
    end
    in_ce = 1'b0;
  endtask

  // Reset while a sample is rotating and overrun/outputs are nonzero.
  task automatic test_reset();
    rx_channel_input = 16'sd16384;
    phase_input      = '0;
    in_ce            = 1'b1;
    step();
    in_ce = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    total++;
    if ({mixed_x, mixed_y, out_x, out_y, ce_mix, ce_down, overrun} !== '0) begin
      bad++;
      $display("FAIL rst_outputs got=%h exp=0",
               {mixed_x, mixed_y, out_x, out_y, ce_mix, ce_down, overrun});
    end
    total++;
    if (dut.state_q !== StIdle) begin
      bad++;
      $display("FAIL rst_state got=%0d exp=%0d", dut.state_q, StIdle);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_rotation();
    int                 lat;
    logic signed [15:0] mx, my;
    rx_channel_input = 16'sd16384;
    phase_input      = '0;
    for (int cyc = 0; cyc < 31; cyc++) begin
      in_ce = (cyc == 0);
      rst   = (cyc == 5);
      total++;
      if (ce_mix !== 1'b0) begin
        bad++;
        $display("FAIL midrst_ce_mix cyc=%0d got=%b exp=0", cyc, ce_mix);
      end
      step();
    end
    in_ce = 1'b0;
    rst   = 1'b0;
    send_sample(16'sd16384, '0, lat, mx, my);
    total++;
    if (lat != 21) begin
      bad++;
      $display("FAIL midrst_latency got=%0d exp=21", lat);
    end
    total++;
    if (mx < 13488 || mx > 13492 || my < -2 || my > 2) begin
      bad++;
      $display("FAIL midrst_value got=(%0d,%0d) exp=(13490,0)+-2", mx, my);
    end
    total++;
    if (overrun !== 1'b0) begin
      bad++;
      $display("FAIL midrst_overrun got=%b exp=0", overrun);
    end
  endtask

  initial begin
    rst              = 1'b1;
    in_ce            = 1'b0;
    phase_input      = '0;
    rx_channel_input = '0;
    step();
    step();
    rst = 1'b0;
    step();
    test_por();
    test_cic_dc();
    test_phase_table();
    test_overrun();
    test_reset();
    test_reset_mid_rotation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
